jtpopeye_sdram_sched: RTL and testbench

Round-robin scheduler that shares the single SDRAM read port among four ROM requesters (main CPU, objects, background, sound) and inserts auto-refresh slots at a fixed period. It sits between the per-requester ROM request caches and the SDRAM controller. It presents one outstanding read at a time to the controller and returns the 32-bit result to the granted requester with a one-cycle ready pulse.

---
 rtl/jtpopeye_sdram_sched_if.sv | 25 ++
 rtl/jtpopeye_sdram_sched.sv | 190 +++++++++++++++++++
 tb/tb_jtpopeye_sdram_sched.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_sdram_sched_if.sv
// Bundle of the requester-side and controller-side read/refresh signals of
// the SDRAM scheduler; master is the scheduler, slave is the environment.
interface jtpopeye_sdram_sched_if;
    logic [3:0]  slot_req;
    logic [87:0] slot_addr;
    logic [3:0]  slot_rdy;
    logic [31:0] slot_dout;
    logic        sdram_req;
    logic        sdram_ack;
    logic [21:0] sdram_addr;
    logic        data_rdy;
    logic [31:0] data_read;
    logic        refresh_req;
    logic        refresh_ack;

    modport master (
        input  slot_req, slot_addr, sdram_ack, data_rdy, data_read, refresh_ack,
        output slot_rdy, slot_dout, sdram_req, sdram_addr, refresh_req
    );

    modport slave (
        output slot_req, slot_addr, sdram_ack, data_rdy, data_read, refresh_ack,
        input  slot_rdy, slot_dout, sdram_req, sdram_addr, refresh_req
    );
endinterface

// File: rtl/jtpopeye_sdram_sched.sv
// Round-robin SDRAM read scheduler for four ROM slots with periodic refresh.
// Optional read watchdog enabled by defining JTPOPEYE_SDRAM_WDOG_EN.
//
// state     | meaning
// IDLE      | no read in flight; refresh or next slot may be granted
// WAIT_ACK  | sdram_req raised, waiting for controller acceptance
// WAIT_DATA | read accepted, waiting for data_rdy
// REFRESH   | refresh_req raised, waiting for refresh_ack
module jtpopeye_sdram_sched #(
    parameter int unsigned REF_PERIOD = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          downloading_i,
    jtpopeye_sdram_sched_if.master        bus,
    output logic                          err_o
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA, REFRESH} state_t;

    localparam logic [15:0] REF_LAST = 16'(REF_PERIOD - 1);

    state_t      state_q,       state_d;
    logic [1:0]  ptr_q,         ptr_d;
    logic [1:0]  sel_q,         sel_d;
    logic [15:0] cnt_q,         cnt_d;
    logic        sdram_req_q,   sdram_req_d;
    logic [21:0] sdram_addr_q,  sdram_addr_d;
    logic        refresh_req_q, refresh_req_d;
    logic [3:0]  slot_rdy_q,    slot_rdy_d;
    logic [31:0] slot_dout_q,   slot_dout_d;

    logic        ref_pending;
    logic [3:0]  masked_req;
    logic [2:0]  pick;
    logic [21:0] addr_w [4];

    // Lowest offset from base wins, giving rotation starting at the pointer.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = base + 2'(i);
            if (req[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) addr_w[k] = bus.slot_addr[22*k +: 22];
    end

    assign ref_pending = (cnt_q == REF_LAST);
    // A slot whose ready pulse is out this cycle still shows its request.
    assign masked_req  = bus.slot_req & ~slot_rdy_q;
    assign pick        = rr_pick(masked_req, ptr_q);

`ifdef JTPOPEYE_SDRAM_WDOG_EN
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        sdram_req_d   = sdram_req_q;
        sdram_addr_d  = sdram_addr_q;
        refresh_req_d = refresh_req_q;
        slot_rdy_d    = 4'b0000;
        slot_dout_d   = slot_dout_q;
        cnt_d         = ref_pending ? cnt_q : cnt_q + 16'd1;
        if (bus.refresh_ack) cnt_d = 16'd0;
`ifdef JTPOPEYE_SDRAM_WDOG_EN
        wd_d  = 8'd0;
        err_d = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (ref_pending) begin
                    refresh_req_d = 1'b1;
                    state_d       = REFRESH;
                end else if (pick[2]) begin
                    sel_d        = pick[1:0];
                    sdram_addr_d = addr_w[pick[1:0]];
                    sdram_req_d  = 1'b1;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (bus.data_rdy) begin
                        slot_dout_d = bus.data_read;
                        slot_rdy_d  = 4'b0001 << sel_q;
                        ptr_d       = sel_q + 2'd1;
                        state_d     = IDLE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (bus.data_rdy) begin
                    slot_dout_d = bus.data_read;
                    slot_rdy_d  = 4'b0001 << sel_q;
                    ptr_d       = sel_q + 2'd1;
                    state_d     = IDLE;
                end
            end
            REFRESH: begin
                if (bus.refresh_ack) begin
                    refresh_req_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef JTPOPEYE_SDRAM_WDOG_EN
        // Only reads still waiting after this cycle are timed.
        if ((state_q == WAIT_ACK || state_q == WAIT_DATA) && state_d != IDLE) begin
            if (wd_q == 8'd255) begin
                sdram_req_d = 1'b0;
                err_d       = 1'b1;
                ptr_d       = sel_q + 2'd1;
                state_d     = IDLE;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
`endif

        if (downloading_i) begin
            state_d       = IDLE;
            sdram_req_d   = 1'b0;
            refresh_req_d = 1'b0;
            slot_rdy_d    = 4'b0000;
            ptr_d         = 2'd0;
            cnt_d         = 16'd0;
`ifdef JTPOPEYE_SDRAM_WDOG_EN
            wd_d          = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            sel_q         <= 2'd0;
            cnt_q         <= 16'd0;
            sdram_req_q   <= 1'b0;
            sdram_addr_q  <= 22'd0;
            refresh_req_q <= 1'b0;
            slot_rdy_q    <= 4'b0000;
            slot_dout_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            sdram_req_q   <= sdram_req_d;
            sdram_addr_q  <= sdram_addr_d;
            refresh_req_q <= refresh_req_d;
            slot_rdy_q    <= slot_rdy_d;
            slot_dout_q   <= slot_dout_d;
        end
    end

`ifdef JTPOPEYE_SDRAM_WDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bus.sdram_req   = sdram_req_q;
    assign bus.sdram_addr  = sdram_addr_q;
    assign bus.refresh_req = refresh_req_q;
    assign bus.slot_rdy    = slot_rdy_q;
    assign bus.slot_dout   = slot_dout_q;
endmodule

// File: tb/tb_jtpopeye_sdram_sched.sv
// Directed bench for jtpopeye_sdram_sched: one default-period instance for
// read/arbitration scenarios and one REF_PERIOD=16 instance for refresh.
module tb_jtpopeye_sdram_sched;
    logic clk = 1'b0;
    logic rst;
    logic dl;
    logic err_a, err_b;

    always #5 clk = ~clk;

    jtpopeye_sdram_sched_if a();
    jtpopeye_sdram_sched_if b();

    jtpopeye_sdram_sched dut_a (
        .clk(clk), .rst(rst), .downloading_i(dl), .bus(a), .err_o(err_a)
    );

    jtpopeye_sdram_sched #(.REF_PERIOD(16)) dut_b (
        .clk(clk), .rst(rst), .downloading_i(dl), .bus(b), .err_o(err_b)
    );

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_addr [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int viol;
        exp_addr[0] = 22'h012345;
        exp_addr[1] = 22'h004000;
        exp_addr[2] = 22'h2ABCDE;
        exp_addr[3] = 22'h3FFFFF;

        rst = 1'b1;
        dl  = 1'b0;
        a.slot_req = 4'b0000; a.sdram_ack = 1'b0; a.data_rdy = 1'b0;
        a.data_read = 32'd0;  a.refresh_ack = 1'b0;
        a.slot_addr = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
        b.slot_req = 4'b0000; b.sdram_ack = 1'b0; b.data_rdy = 1'b0;
        b.data_read = 32'd0;  b.refresh_ack = 1'b0;
        b.slot_addr = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};

        #12;
        chk("rst_sdram_req",   a.sdram_req,   0);
        chk("rst_sdram_addr",  a.sdram_addr,  0);
        chk("rst_refresh_req", a.refresh_req, 0);
        chk("rst_slot_rdy",    a.slot_rdy,    0);
        chk("rst_slot_dout",   a.slot_dout,   0);
        chk("rst_err",         err_a,         0);
        chk("rst_b_refresh",   b.refresh_req, 0);
        @(negedge clk);
        rst = 1'b0;

        // single read on slot 1
        a.slot_req = 4'b0010;
        tick();
        chk("single_grant_req",  a.sdram_req,  1);
        chk("single_grant_addr", a.sdram_addr, 22'h004000);
        tick();
        chk("single_hold_req", a.sdram_req, 1);
        a.sdram_ack = 1'b1;
        tick();
        chk("single_ack_req", a.sdram_req, 0);
        a.sdram_ack = 1'b0;
        tick();
        tick();
        chk("single_addr_stable", a.sdram_addr, 22'h004000);
        chk("single_no_rdy_yet",  a.slot_rdy,   0);
        a.data_rdy = 1'b1; a.data_read = 32'hDEADBEEF;
        tick();
        chk("single_rdy",  a.slot_rdy,  4'b0010);
        chk("single_dout", a.slot_dout, 32'hDEADBEEF);
        a.data_rdy = 1'b0;
        tick();
        chk("single_rdy_pulse", a.slot_rdy,  0);
        chk("single_mask",      a.sdram_req, 0);
        a.slot_req = 4'b0000;
        tick();
        chk("single_idle", a.sdram_req, 0);

        // asynchronous reset mid-transaction
        a.slot_req = 4'b0100;
        tick();
        chk("arst_pre_req", a.sdram_req, 1);
        rst = 1'b1;
        a.slot_req = 4'b0000;
        #1;
        chk("arst_req",  a.sdram_req,  0);
        chk("arst_addr", a.sdram_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // round robin with simultaneous ack+data
        a.slot_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int e;
            e = i % 4;
            tick();
            chk($sformatf("rr%0d_req", i),  a.sdram_req,  1);
            chk($sformatf("rr%0d_addr", i), a.sdram_addr, exp_addr[e]);
            a.sdram_ack = 1'b1; a.data_rdy = 1'b1; a.data_read = 32'hA5A50000 + i;
            tick();
            chk($sformatf("rr%0d_rdy", i),  a.slot_rdy,  4'b0001 << e);
            chk($sformatf("rr%0d_dout", i), a.slot_dout, 32'hA5A50000 + i);
            chk($sformatf("rr%0d_req_lo", i), a.sdram_req, 0);
            a.sdram_ack = 1'b0; a.data_rdy = 1'b0;
            a.slot_req[e] = 1'b0;
            if (e == 3) a.slot_req[0] = 1'b1;
        end
        tick();
        chk("rr_single_pulse", a.slot_rdy, 0);

        // downloading drops an in-flight read and resets the pointer
        a.slot_req = 4'b0100;
        tick();
        chk("dl_grant_addr", a.sdram_addr, exp_addr[2]);
        a.sdram_ack = 1'b1;
        tick();
        chk("dl_ack_req", a.sdram_req, 0);
        a.sdram_ack = 1'b0;
        dl = 1'b1;
        tick();
        a.data_rdy = 1'b1; a.data_read = 32'h12345678;
        tick();
        chk("dl_no_rdy",  a.slot_rdy,  0);
        chk("dl_req_low", a.sdram_req, 0);
        dl = 1'b0; a.data_rdy = 1'b0;
        a.slot_req = 4'b1001;
        tick();
        chk("dl_ptr0_req",  a.sdram_req,  1);
        chk("dl_ptr0_addr", a.sdram_addr, exp_addr[0]);
        a.sdram_ack = 1'b1; a.data_rdy = 1'b1; a.data_read = 32'h0BADF00D;
        tick();
        chk("dl_after_rdy", a.slot_rdy, 4'b0001);
        a.sdram_ack = 1'b0; a.data_rdy = 1'b0; a.slot_req = 4'b0000;

        // refresh on the short-period instance
        do_reset();
        n = 0;
        while (n < 40 && b.refresh_req !== 1'b1) begin
            tick();
            n++;
        end
        chk("ref_first_latency", n, 16);
        b.slot_req = 4'b0011;
        viol = 0;
        repeat (3) begin
            tick();
            if (b.sdram_req !== 1'b0) viol++;
        end
        chk("ref_blocks_reads", viol, 0);
        chk("ref_req_held", b.refresh_req, 1);
        b.refresh_ack = 1'b1;
        tick();
        chk("ref_ack_clear", b.refresh_req, 0);
        b.refresh_ack = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (b.refresh_req === 1'b1) break;
            b.sdram_ack = b.sdram_req;
            b.data_rdy  = b.sdram_req;
            b.data_read = n;
        end
        chk("ref_deferred_latency", n, 17);
        chk("ref_no_read_inflight", b.sdram_req, 0);
        b.slot_req = 4'b0000; b.sdram_ack = 1'b0; b.data_rdy = 1'b0;

        // watchdog
        do_reset();
        a.slot_req = 4'b0001;
        tick();
        chk("wd_grant", a.sdram_req, 1);
`ifdef JTPOPEYE_SDRAM_WDOG_EN
        n = 0;
        while (n < 300 && a.sdram_req === 1'b1) begin
            tick();
            n++;
        end
        chk("wd_timeout_cycles", n, 256);
        chk("wd_err", err_a, 1);
        chk("wd_no_rdy", a.slot_rdy, 0);
        a.slot_req = 4'b0011;
        tick();
        chk("wd_next_req",  a.sdram_req,  1);
        chk("wd_next_addr", a.sdram_addr, exp_addr[1]);
`else
        repeat (300) tick();
        chk("nowd_still_waiting", a.sdram_req, 1);
        chk("nowd_err", err_a, 0);
`endif
        a.slot_req = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
